// File: rtl/ysyx_22041207_div_if.sv
// Request/response bundle between the EX-stage ALU (master) and the iterative divider (slave).
// Handshake: a request is taken on a rising edge where div_valid & div_ready & ~flush; out_valid pulses for one cycle when quotient/remainder are fresh.
interface ysyx_22041207_div_if #(
  parameter int XLEN = 64
);
  logic            div_valid;
  logic            flush;
  logic            div_signed;
  logic            divw;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output div_valid, flush, div_signed, divw, dividend, divisor,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, flush, div_signed, divw, dividend, divisor,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22041207_div.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes, sign fix-up and
// word-mode sign extension applied when the last bit is produced.
module ysyx_22041207_div #(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22041207_div_if.slave    bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [6:0]      count_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            word_q;
  logic            div0_q;
  logic            out_valid_q;
  logic [XLEN-1:0] quotient_q;
  logic [XLEN-1:0] remainder_q;

  // Operand preparation on the live inputs; only used on the accept edge.
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] a_shift;
  logic            sa;
  logic            sb;

  always_comb begin
    a_ext = bus.dividend;
    b_ext = bus.divisor;
    if (bus.divw) begin
      a_ext = bus.div_signed ? {{32{bus.dividend[31]}}, bus.dividend[31:0]}
                             : {32'b0, bus.dividend[31:0]};
      b_ext = bus.div_signed ? {{32{bus.divisor[31]}}, bus.divisor[31:0]}
                             : {32'b0, bus.divisor[31:0]};
    end
    sa    = bus.div_signed & a_ext[XLEN-1];
    sb    = bus.div_signed & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    // Word operands are parked in the top half so the same MSB-first shift works for 32 steps.
    a_shift = bus.divw ? {a_mag[31:0], 32'b0} : a_mag;
  end

  // One restoring step plus the signed/word fix-up of its result.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] q_sgn;
  logic [XLEN-1:0] r_sgn;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    trial    = rem_sh - {1'b0, dsr_q};
    ge       = ~trial[XLEN];
    rem_step = ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
    q_sgn    = neg_q_q ? -quo_step : quo_step;
    r_sgn    = neg_r_q ? -rem_step : rem_step;
    if (div0_q) begin
      // rem_q was loaded with the prepared dividend at accept time.
      q_sgn = '1;
      r_sgn = rem_q;
    end
    q_fin = word_q ? {{32{q_sgn[31]}}, q_sgn[31:0]} : q_sgn;
    r_fin = word_q ? {{32{r_sgn[31]}}, r_sgn[31:0]} : r_sgn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      word_q      <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (bus.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (bus.div_valid) begin
            state_q <= S_BUSY;
            count_q <= bus.divw ? 7'd32 : 7'd64;
            quo_q   <= a_shift;
            dsr_q   <= b_mag;
            neg_q_q <= sa ^ sb;
            neg_r_q <= sa;
            word_q  <= bus.divw;
            div0_q  <= (b_mag == '0);
            rem_q   <= (b_mag == '0) ? a_ext : '0;
          end
        end
        S_BUSY: begin
          if (div0_q || count_q == 7'd1) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            quotient_q  <= q_fin;
            remainder_q <= r_fin;
          end
          if (!div0_q) begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= count_q - 7'd1;
          end
        end
        S_DONE: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.div_ready = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ysyx_22041207_div.sv
// Directed-vector bench for the iterative divider: result values, completion latency,
// ready/out_valid timing, flush and asynchronous reset corner cases.
module tb_ysyx_22041207_div;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;

  ysyx_22041207_div_if #(.XLEN(64)) bus ();

  ysyx_22041207_div #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        w;
    logic [63:0] eq;
    logic [63:0] er;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.div_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.div_signed = 1'b0;
    bus.divw       = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
  endtask

  // Issue one request and wait (bounded) for out_valid; lat = edges after the accept edge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                        output logic [63:0] q, output logic [63:0] r, output int lat,
                        output bit ready_ok);
    int guard;
    lat = -1; ready_ok = 1'b1; q = '0; r = '0; guard = 0;
    while (!bus.div_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    bus.dividend = a; bus.divisor = b; bus.div_signed = s; bus.divw = w;
    bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    // Scramble inputs after accept: the divider must use its latched copy.
    bus.dividend = {$urandom, $urandom};
    bus.divisor  = {$urandom, $urandom};
    bus.div_signed = 1'($urandom_range(0, 1));
    bus.divw       = 1'($urandom_range(0, 1));
    if (bus.div_ready) ready_ok = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k; q = bus.quotient; r = bus.remainder;
        break;
      end
      if (bus.div_ready) ready_ok = 1'b0;
    end
  endtask

  logic [63:0] q;
  logic [63:0] r;
  int          lat;
  bit          rdy_ok;
  bit          saw_ov;
  logic [63:0] prev_q;
  logic [63:0] prev_r;

  initial begin
    n_cmp = 0; n_err = 0;
    vecs[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 64};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[2]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64};
    vecs[3]  = '{64'h1234, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
    vecs[4]  = '{64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
    vecs[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                 64'h8000_0000_0000_0000, 64'd0, 64};
    vecs[6]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
                 64'hFFFF_FFFF_8000_0000, 64'd0, 32};
    vecs[7]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0,
                 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 64};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0,
                 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[10] = '{64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007, 1'b1, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 32};
    vecs[11] = '{64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 1'b0, 1'b1,
                 64'd14, 64'd2, 32};
    vecs[12] = '{64'd0, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0, 64};
    vecs[13] = '{64'd5, 64'd10, 1'b1, 1'b0, 64'd0, 64'd5, 64};

    // Reset state
    drive_idle();
    rst = 1'b0;
    #12;
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_quotient", bus.quotient, 64'd0);
    chk("rst_remainder", bus.remainder, 64'd0);
    chk("rst_ready", {63'b0, bus.div_ready}, 64'd1);
    chk("rst_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].w, q, r, lat, rdy_ok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), q, vecs[i].eq);
      chk($sformatf("v%0d_remainder", i), r, vecs[i].er);
      chk($sformatf("v%0d_ready_low_busy", i), {63'b0, rdy_ok}, 64'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_one_cycle", i), {63'b0, bus.out_valid}, 64'd0);
      chk($sformatf("v%0d_ready_after", i), {63'b0, bus.div_ready}, 64'd1);
      chk($sformatf("v%0d_hold_q", i), bus.quotient, vecs[i].eq);
    end
    prev_q = vecs[13].eq;
    prev_r = vecs[13].er;

    // Flush on E10 of a 64-bit op
    @(negedge clk);
    bus.dividend = 64'd1000; bus.divisor = 64'd3; bus.div_signed = 1'b0; bus.divw = 1'b0;
    bus.div_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    chk("flush_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
    chk("flush_ready", {63'b0, bus.div_ready}, 64'd1);
    chk("flush_keep_q", bus.quotient, prev_q);
    chk("flush_keep_r", bus.remainder, prev_r);
    saw_ov = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_ov = 1'b1;
    end
    chk("flush_no_out_valid", {63'b0, saw_ov}, 64'd0);
    run_op(64'd9, 64'd3, 1'b0, 1'b0, q, r, lat, rdy_ok);
    chk("post_flush_latency", 64'(lat), 64'd64);
    chk("post_flush_q", q, 64'd3);
    chk("post_flush_r", r, 64'd0);

    // div_valid held high through DONE: not taken in DONE, taken once back in IDLE
    @(posedge clk); #1;
    @(negedge clk);
    bus.dividend = 64'd20; bus.divisor = 64'd4; bus.div_signed = 1'b0; bus.divw = 1'b0;
    bus.div_valid = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = k; break; end
    end
    chk("hold_valid_latency", 64'(lat), 64'd64);
    chk("hold_valid_q", bus.quotient, 64'd5);
    chk("done_state", {62'b0, dbg_state}, {62'b0, ST_DONE});
    chk("done_ready", {63'b0, bus.div_ready}, 64'd0);
    @(posedge clk); #1;
    chk("done_not_accepted", {62'b0, dbg_state}, {62'b0, ST_IDLE});
    @(posedge clk); #1;
    chk("idle_accepted", {62'b0, dbg_state}, {62'b0, ST_BUSY});
    @(negedge clk); bus.div_valid = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    chk("flush_from_busy", {62'b0, dbg_state}, {62'b0, ST_IDLE});

    // Flush while idle blocks an accept
    @(negedge clk); bus.div_valid = 1'b1; bus.flush = 1'b1;
    bus.dividend = 64'd50; bus.divisor = 64'd5;
    @(posedge clk); #1;
    chk("idle_flush_blocks", {62'b0, dbg_state}, {62'b0, ST_IDLE});
    bus.div_valid = 1'b0; bus.flush = 1'b0;

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    bus.dividend = 64'd77; bus.divisor = 64'd7; bus.div_valid = 1'b1;
    @(posedge clk); #1; bus.div_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("arst_quotient", bus.quotient, 64'd0);
    chk("arst_remainder", bus.remainder, 64'd0);
    chk("arst_ready", {63'b0, bus.div_ready}, 64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); bus.div_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    chk("arst_valid_flush_blocked", {62'b0, dbg_state}, {62'b0, ST_IDLE});
    bus.div_valid = 1'b0; bus.flush = 1'b0;
    saw_ov = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_ov = 1'b1;
    end
    chk("arst_no_out_valid", {63'b0, saw_ov}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
